// File: rtl/imem_pkg.sv
// Shared constants for the instruction-memory responder: FSM encoding, wait counter width, fault NOP.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package imem_pkg;

   localparam int          WAIT_W    = 4;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   // A fetch faults when it is not word aligned or lies beyond the 2^aw-word store.
   function automatic logic addr_fault(input logic [31:0] addr, input int aw);
      return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != 32'd0);
   endfunction

endpackage

// File: rtl/imem_array.sv
// DEPTH x 32 instruction store with one write port and one registered read port.
// Latency: read data appears one clock after rd_en; a same-edge write to that word returns old data.
// Backpressure: none; both ports are accepted every cycle they are enabled.
module imem_array
   import imem_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_idx,
   input  logic [31:0]   wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_idx,
   output logic [31:0]   rd_data
);

   logic [31:0] mem [DEPTH];

   // Storage write; contents deliberately survive reset so a loaded program persists.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_idx] <= wr_data;
   end

   // Registered read; non-blocking semantics give the pre-write word on a same-edge collision.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)      rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_idx];
   end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder serving fetches over valid/ready with programmable wait states; IMEM_ERR_EN adds resp_err.
// Latency: resp_valid rises WAIT_CYCLES+1 cycles after the accept cycle; peak one fetch per WAIT_CYCLES+1 cycles.
// Backpressure: response held stable until resp_ready; req_ready drops during loads, flush, WAIT, or an unconsumed response.
module imem_responder
   import imem_pkg::*;
#(
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_instr,
   output logic [31:0] resp_addr,
   input  logic        flush,
   input  logic        ld_en,
   input  logic [31:0] ld_addr,
   input  logic [31:0] ld_data
`ifdef IMEM_ERR_EN
   ,
   output logic        resp_err
`endif
);

   localparam int                AW          = $clog2(DEPTH);
   localparam logic [WAIT_W-1:0] WAIT_INIT   = WAIT_W'(WAIT_CYCLES);
   localparam logic [1:0]        ST_ACCEPTED = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic [WAIT_W-1:0] cnt;
   logic [31:0]       addr_q;
   logic              accept;
   logic              wait_done;
   logic              rd_en;
   logic              wr_en;
   logic [31:0]       rd_addr;
   logic [31:0]       rd_data;
   logic              unused_ld_bits;

   assign req_ready  = !ld_en && !flush &&
                       ((state == ST_IDLE) || ((state == ST_RESP) && resp_ready));
   assign accept     = req_valid && req_ready;
   assign resp_valid = (state == ST_RESP);

   // The last wait cycle and a zero-wait accept both launch the memory read.
   assign wait_done = (state == ST_WAIT) && (cnt == WAIT_W'(1)) && !flush;
   assign rd_en     = wait_done || (accept && (WAIT_CYCLES == 0));
   assign rd_addr   = (state == ST_WAIT) ? addr_q : req_addr;

`ifdef IMEM_ERR_EN
   assign wr_en = ld_en && ((ld_addr >> (AW + 2)) == 32'd0);
`else
   assign wr_en = ld_en;
`endif

   // Byte offset and out-of-range bits of the loader address never select a word.
   assign unused_ld_bits = ^{ld_addr[31:AW+2], ld_addr[1:0]};

   imem_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_idx  (ld_addr[AW+1:2]),
      .wr_data (ld_data),
      .rd_en   (rd_en),
      .rd_idx  (rd_addr[AW+1:2]),
      .rd_data (rd_data)
   );

   // Next-state selection; flush overrides everything and returns to IDLE.
   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (accept) state_nxt = ST_ACCEPTED;
            ST_WAIT: if (cnt == WAIT_W'(1)) state_nxt = ST_RESP;
            ST_RESP: if (resp_ready) state_nxt = accept ? ST_ACCEPTED : ST_IDLE;
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   // FSM state, wait countdown and the latched fetch address.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         addr_q <= '0;
      end else begin
         state <= state_nxt;
         if (flush) begin
            cnt <= '0;
         end else if (accept) begin
            cnt    <= WAIT_INIT;
            addr_q <= req_addr;
         end else if ((state == ST_WAIT) && (cnt != '0)) begin
            cnt <= cnt - WAIT_W'(1);
         end
      end
   end

   // Response address is captured on the same edge as the memory read so it tracks the data.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)      resp_addr <= '0;
      else if (rd_en) resp_addr <= rd_addr;
   end

`ifdef IMEM_ERR_EN
   // Fault flag registered with the read; a faulting fetch returns a NOP instead of array data.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)      resp_err <= 1'b0;
      else if (rd_en) resp_err <= addr_fault(rd_addr, AW);
   end

   assign resp_instr = resp_err ? NOP_INSTR : rd_data;
`else
   assign resp_instr = rd_data;
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: directed scenarios with literal expectations plus random traffic.
// Latency: a transaction-level model predicts resp_valid WAIT_CYCLES+1 cycles after each accept.
// Backpressure: resp_ready, flush and ld_en are randomised; the model predicts req_ready every cycle.
module tb_imem_responder;

   localparam int DEPTH = 256;
   localparam int W     = 1;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_instr;
   logic [31:0] resp_addr;
   logic        flush;
   logic        ld_en;
   logic [31:0] ld_addr;
   logic [31:0] ld_data;
`ifdef IMEM_ERR_EN
   logic        resp_err;
`endif

   always #5 clk = ~clk;

   imem_responder #(
      .DEPTH       (DEPTH),
      .WAIT_CYCLES (W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_instr (resp_instr),
      .resp_addr  (resp_addr),
      .flush      (flush),
      .ld_en      (ld_en),
      .ld_addr    (ld_addr),
      .ld_data    (ld_data)
`ifdef IMEM_ERR_EN
      ,
      .resp_err   (resp_err)
`endif
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // Transaction-level model: a word store, one outstanding fetch and one pending response.
   logic [31:0] mem_m [DEPTH];
   bit          m_inflight = 1'b0;
   bit          m_valid    = 1'b0;
   bit          m_err      = 1'b0;
   int          m_rd_cyc   = 0;
   logic [31:0] m_addr     = '0;
   logic [31:0] m_instr    = '0;
   logic [31:0] m_raddr    = '0;

   function automatic bit fault(input logic [31:0] a);
      return (a[1:0] != 2'b00) || (a >= 32'(DEPTH * 4));
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'((a >> 2) % 32'(DEPTH));
   endfunction

   task automatic model_read(input logic [31:0] a);
      m_raddr = a;
      m_valid = 1'b1;
`ifdef IMEM_ERR_EN
      m_err   = fault(a);
      m_instr = m_err ? 32'h0000_0013 : mem_m[widx(a)];
`else
      m_err   = 1'b0;
      m_instr = mem_m[widx(a)];
`endif
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, got, exp);
      end
   endtask

   // One clock cycle: drive inputs, compare outputs against the model, then advance the model.
   task automatic step(input bit rv, input logic [31:0] ra, input bit rr, input bit fl,
                       input bit le, input logic [31:0] la, input logic [31:0] ld);
      bit exp_ready;
      bit acc;
      @(negedge clk);
      req_valid  = rv;
      req_addr   = ra;
      resp_ready = rr;
      flush      = fl;
      ld_en      = le;
      ld_addr    = la;
      ld_data    = ld;
      #1;
      exp_ready = !le && !fl && ((!m_inflight && !m_valid) || (m_valid && rr));
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("resp_valid", 32'(resp_valid), 32'(m_valid));
      if (m_valid) begin
         chk("resp_instr", resp_instr, m_instr);
         chk("resp_addr", resp_addr, m_raddr);
`ifdef IMEM_ERR_EN
         chk("resp_err", 32'(resp_err), 32'(m_err));
`endif
      end
      acc = rv && exp_ready;
      if (fl) begin
         m_inflight = 1'b0;
         m_valid    = 1'b0;
      end else begin
         if (m_valid && rr) m_valid = 1'b0;
         if (m_inflight && (cyc == m_rd_cyc)) begin
            model_read(m_addr);
            m_inflight = 1'b0;
         end
         if (acc) begin
            if (W == 0) begin
               model_read(ra);
            end else begin
               m_inflight = 1'b1;
               m_addr     = ra;
               m_rd_cyc   = cyc + W;
            end
         end
      end
`ifdef IMEM_ERR_EN
      if (le && (la < 32'(DEPTH * 4))) mem_m[widx(la)] = ld;
`else
      if (le) mem_m[widx(la)] = ld;
`endif
      cyc++;
   endtask

   task automatic idle(input bit rr);
      step(1'b0, 32'h0, rr, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic load(input logic [31:0] a, input logic [31:0] d);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, a, d);
   endtask

   task automatic fetch(input logic [31:0] a, input bit rr);
      step(1'b1, a, rr, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   logic [31:0] hold_instr;
   logic [31:0] hold_addr;

   initial begin
      reset      = 1'b0;
      req_valid  = 1'b0;
      req_addr   = '0;
      resp_ready = 1'b0;
      flush      = 1'b0;
      ld_en      = 1'b0;
      ld_addr    = '0;
      ld_data    = '0;
      #2 reset = 1'b1;
      #1;
      chk("rst_resp_valid", 32'(resp_valid), 32'h0);
      chk("rst_resp_instr", resp_instr, 32'h0);
      chk("rst_resp_addr", resp_addr, 32'h0);
      chk("rst_req_ready", 32'(req_ready), 32'h1);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Give every word a known value, then pin the words the directed cases use.
      for (int i = 0; i < DEPTH; i++) load(32'(i * 4), $urandom);
      load(32'h04, 32'h1111_1111);
      load(32'h08, 32'h2222_2222);
      load(32'h0C, 32'h3333_3333);
      load(32'h10, 32'h4444_4444);
      load(32'h14, 32'h5555_5555);

      // Load then fetch word 0; response two cycles after the accept cycle.
      load(32'h0, 32'h0050_0093);
      fetch(32'h0, 1'b0);
      chk("t1_accept_ready", 32'(req_ready), 32'h1);
      idle(1'b0);
      chk("t1_wait_no_valid", 32'(resp_valid), 32'h0);
      idle(1'b0);
      chk("t1_valid", 32'(resp_valid), 32'h1);
      chk("t1_instr", resp_instr, 32'h0050_0093);
      chk("t1_addr", resp_addr, 32'h0);

      // Stall the response, then chain fetches 4 and 8 on the handshake cycles.
      hold_instr = resp_instr;
      hold_addr  = resp_addr;
      for (int i = 0; i < 2; i++) begin
         idle(1'b0);
         chk("t2_hold_instr", resp_instr, hold_instr);
         chk("t2_hold_addr", resp_addr, hold_addr);
      end
      fetch(32'h4, 1'b1);
      chk("t2_b2b_ready_4", 32'(req_ready), 32'h1);
      idle(1'b0);
      fetch(32'h8, 1'b1);
      chk("t2_instr_4", resp_instr, 32'h1111_1111);
      chk("t2_b2b_ready_8", 32'(req_ready), 32'h1);
      idle(1'b0);
      idle(1'b1);
      chk("t2_instr_8", resp_instr, 32'h2222_2222);
      chk("t2_addr_8", resp_addr, 32'h8);

      // Flush during WAIT kills the fetch; the next fetch is unaffected.
      fetch(32'h10, 1'b1);
      step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
      idle(1'b1);
      chk("t3_flushed_1", 32'(resp_valid), 32'h0);
      idle(1'b1);
      chk("t3_flushed_2", 32'(resp_valid), 32'h0);
      fetch(32'h14, 1'b1);
      idle(1'b1);
      idle(1'b1);
      chk("t3_instr_14", resp_instr, 32'h5555_5555);

      // A load blocks accepts but not a fetch already waiting; same-edge collision reads old data.
      step(1'b1, 32'h0, 1'b1, 1'b0, 1'b1, 32'h40, 32'h1234_5678);
      chk("t4_ld_blocks", 32'(req_ready), 32'h0);
      fetch(32'h0C, 1'b1);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0C, 32'hDEAD_BEEF);
      idle(1'b1);
      chk("t4_old_data", resp_instr, 32'h3333_3333);
      fetch(32'h0C, 1'b1);
      idle(1'b1);
      idle(1'b1);
      chk("t4_new_data", resp_instr, 32'hDEAD_BEEF);

      // Out-of-range fetch: wraps without the fault option, faults with it.
      fetch(32'(DEPTH * 4 + 8), 1'b1);
      idle(1'b1);
      idle(1'b1);
      chk("t5_addr", resp_addr, 32'(DEPTH * 4 + 8));
`ifdef IMEM_ERR_EN
      chk("t5_instr_nop", resp_instr, 32'h0000_0013);
      chk("t5_err", 32'(resp_err), 32'h1);
`else
      chk("t5_instr_wrap", resp_instr, 32'h2222_2222);
`endif

      // Randomised traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] ra;
         logic [31:0] la;
         int sel;
         sel = $urandom_range(0, 9);
         if (sel < 8)       ra = 32'($urandom_range(0, DEPTH - 1)) << 2;
         else if (sel == 8) ra = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
         else               ra = $urandom;
         la = ($urandom_range(0, 9) == 0) ? $urandom : (32'($urandom_range(0, DEPTH - 1)) << 2);
         step($urandom_range(0, 9) < 6, ra, $urandom_range(0, 9) < 7,
              $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 2, la, $urandom);
      end

      // Reset while a response is pending drops it immediately; memory survives.
      idle(1'b1);
      idle(1'b1);
      idle(1'b1);
      fetch(32'h4, 1'b0);
      idle(1'b0);
      idle(1'b0);
      chk("t6_pre_valid", 32'(resp_valid), 32'h1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("t6_rst_valid", 32'(resp_valid), 32'h0);
      chk("t6_rst_instr", resp_instr, 32'h0);
      chk("t6_rst_addr", resp_addr, 32'h0);
      m_inflight = 1'b0;
      m_valid    = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      idle(1'b1);
      chk("t6_ready_after", 32'(req_ready), 32'h1);
      fetch(32'h14, 1'b1);
      idle(1'b1);
      idle(1'b1);
      idle(1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
